stdout_uart_tx: RTL and testbench

- UART transmitter driving the board RsTx pin. It is the transmit-side counterpart of the program-loader receive path.
- Accepts bytes written by the core's stdout path, buffers them in a small FIFO, and serialises them as 8N1 frames.
- Sits beside the core and shares its clock domain.
- Lets the CPU print to the host terminal instead of only to the 7-segment display.

---
 rtl/uart_pkg.sv | 13 +
 rtl/stdout_uart_tx_if.sv | 13 +
 rtl/uart_tx_serializer.sv | 102 ++++++++++
 rtl/stdout_uart_tx.sv | 80 ++++++++
 tb/tb_stdout_uart_tx.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and timing helpers for the stdout UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/stdout_uart_tx_if.sv
// Byte-write port and status/serial outputs of the stdout UART transmitter.
interface stdout_uart_tx_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic       busy;
    logic       overflow;
    logic       tx;

    modport master (output wr_en, wr_data, input full, empty, busy, overflow, tx);
    modport slave  (input wr_en, wr_data, output full, empty, busy, overflow, tx);
endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 serialiser: FSM, baud counter and shift register. tx/busy are registered,
// so they follow the state register by one cycle.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       ready_for_next
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d        = state_q;
        cnt_d          = bit_end ? '0 : cnt_q + 1'b1;
        bit_idx_d      = bit_idx_q;
        shift_d        = shift_q;
        ready_for_next = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d          = '0;
                ready_for_next = 1'b1;
                if (start) begin
                    shift_d = data;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_BIT) state_d = STOP;
                end
            end
            STOP: begin
                // Chaining straight into START keeps back-to-back frames gapless.
                if (bit_end) begin
                    ready_for_next = 1'b1;
                    if (start) begin
                        shift_d = data;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        tx_d   = (state_q == START) ? 1'b0 :
                 (state_q == DATA)  ? shift_q[0] : 1'b1;
        busy_d = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: rtl/stdout_uart_tx.sv
// stdout UART transmitter: byte FIFO feeding an 8N1 serialiser on RsTx, with a
// sticky overflow flag for writes dropped while the FIFO is full.
module stdout_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input logic             clk,
    input logic             reset,
    stdout_uart_tx_if.slave bus
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             full, empty, wr_ok, pop, ready_for_next;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    // full is taken from the registered count, so a same-cycle pop never frees room.
    assign wr_ok = bus.wr_en & ~full;
    assign pop   = ready_for_next & ~empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (bus.wr_en & full);
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk            (clk),
        .reset          (reset),
        .start          (~empty),
        .data           (mem_q[rd_ptr_q]),
        .tx             (bus.tx),
        .busy           (bus.busy),
        .ready_for_next (ready_for_next)
    );

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Bench for stdout_uart_tx: a fast-baud instance checked against a FIFO/frame
// scheduler model and a line receiver, plus a default-baud instance for timing.
module tb_stdout_uart_tx;

    localparam int DEPTH = 16;
    localparam int CPB   = 16;
    localparam int CPB1  = 868;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    stdout_uart_tx_if if0 ();
    stdout_uart_tx_if if1 ();

    stdout_uart_tx #(.CLK_HZ(16), .BAUD(1), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk(clk), .reset(reset), .bus(if0));
    stdout_uart_tx dut1 (
        .clk(clk), .reset(reset), .bus(if1));

    always #5 clk = ~clk;

    // Reference: FIFO as a queue; the line is free 10*CPB edges after each pop.
    longint     cyc = 0;
    longint     m_free = 0;
    logic [7:0] m_q[$];
    logic [7:0] m_sent[$];
    bit         m_ovf = 1'b0;
    bit         m_acc, m_pop;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_sent.delete();
            m_ovf  = 1'b0;
            m_free = 0;
        end else begin
            cyc++;
            m_acc = if0.wr_en && (m_q.size() < DEPTH);
            m_pop = (m_q.size() != 0) && (cyc >= m_free);
            if (if0.wr_en && m_q.size() >= DEPTH) m_ovf = 1'b1;
            if (m_pop) begin
                m_sent.push_back(m_q.pop_front());
                m_free = cyc + 10 * CPB;
            end
            if (m_acc) m_q.push_back(if0.wr_data);
        end
    end

    // Line receiver: samples mid-bit after the start edge.
    int         rx_t = 0;
    bit         rx_act = 1'b0;
    logic [7:0] rx_sh;
    logic [7:0] rx_q[$];
    int         rx_stop_err = 0;

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            rx_act = 1'b0;
            rx_q.delete();
        end else if (!rx_act) begin
            if (if0.tx === 1'b0) begin
                rx_act = 1'b1;
                rx_t   = 0;
            end
        end else begin
            rx_t++;
            if (rx_t % CPB == CPB / 2 && rx_t / CPB >= 1 && rx_t / CPB <= 8)
                rx_sh = {if0.tx, rx_sh[7:1]};
            if (rx_t == 9 * CPB + CPB / 2) begin
                if (if0.tx !== 1'b1) rx_stop_err++;
                rx_q.push_back(rx_sh);
                rx_act = 1'b0;
            end
        end
    end

    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return d[k-1];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        if0.wr_en = 1'b0;
        if1.wr_en = 1'b0;
        if0.wr_data = '0;
        if1.wr_data = '0;
        reset = 1'b0;
        repeat (3) tick;
        reset = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        do_reset;
        @(negedge clk);
        total++; if (if0.tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", if0.tx); end
        total++; if (if0.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", if0.busy); end
        total++; if (if0.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", if0.full); end
        total++; if (if0.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", if0.empty); end
        total++; if (if0.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", if0.overflow); end
        total++; if (if1.tx !== 1'b1) begin bad++; $display("FAIL reset_tx1 got=%b want=1", if1.tx); end
    endtask

    task automatic test_single;
        logic [7:0] d;
        int errs, busy_cnt;
        d = 8'h55;
        tick;
        if0.wr_en = 1'b1; if0.wr_data = d;
        tick;
        if0.wr_en = 1'b0;
        tick;
        total++; if (if0.tx !== 1'b1 || if0.busy !== 1'b0) begin
            bad++; $display("FAIL single_latency tx=%b busy=%b want tx=1 busy=0", if0.tx, if0.busy); end
        errs = 0; busy_cnt = 0;
        for (int k = 0; k < 170; k++) begin
            tick;
            if (if0.tx !== ((k < 160) ? frame_bit(d, k / CPB) : 1'b1)) errs++;
            if (if0.busy === 1'b1) busy_cnt++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL single_frame_bits got=%0d bad cycles want=0", errs); end
        total++; if (busy_cnt != 160) begin bad++; $display("FAIL single_busy_len got=%0d want=160", busy_cnt); end
        total++; if (if0.empty !== 1'b1) begin bad++; $display("FAIL single_empty got=%b want=1", if0.empty); end
        total++; if (rx_q.size() != 1 || rx_q[0] !== d) begin
            bad++; $display("FAIL single_rx got_n=%0d got=%h want=%h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, d); end
        rx_q.delete();
    endtask

    task automatic test_back_to_back;
        logic [7:0] d [2];
        int errs, busy_cnt;
        d[0] = 8'h41; d[1] = 8'h0A;
        tick;
        if0.wr_en = 1'b1; if0.wr_data = d[0];
        tick;
        if0.wr_data = d[1];
        tick;
        if0.wr_en = 1'b0;
        errs = 0; busy_cnt = 0;
        for (int k = 0; k < 330; k++) begin
            tick;
            if (if0.tx !== ((k < 320) ? frame_bit(d[k / 160], (k % 160) / CPB) : 1'b1)) errs++;
            if (if0.busy === 1'b1) busy_cnt++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL b2b_frame_bits got=%0d bad cycles want=0", errs); end
        total++; if (busy_cnt != 320) begin bad++; $display("FAIL b2b_busy_len got=%0d want=320", busy_cnt); end
        total++; if (rx_q.size() != 2 || rx_q[0] !== d[0] || rx_q[1] !== d[1]) begin
            bad++; $display("FAIL b2b_rx got_n=%0d want 41,0a", rx_q.size()); end
        rx_q.delete();
    endtask

    task automatic drain_and_compare(input string name);
        int flag_errs;
        bit done;
        flag_errs = 0; done = 1'b0;
        for (int i = 0; i < 6000 && !done; i++) begin
            tick;
            if (if0.empty !== (m_q.size() == 0) || if0.full !== (m_q.size() == DEPTH) || if0.overflow !== m_ovf)
                flag_errs++;
            if (m_q.size() == 0 && cyc >= m_free + 4) done = 1'b1;
        end
        total++; if (!done) begin bad++; $display("FAIL %s_drain_timeout got=timeout want=drained", name); end
        total++; if (flag_errs != 0) begin bad++; $display("FAIL %s_flags got=%0d bad cycles want=0", name, flag_errs); end
        total++; if (rx_q != m_sent) begin
            bad++; $display("FAIL %s_rx_stream got_n=%0d want_n=%0d", name, rx_q.size(), m_sent.size()); end
    endtask

    task automatic test_fifo_fill;
        int flag_errs;
        bit saw_full;
        do_reset;
        flag_errs = 0; saw_full = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if0.wr_en = 1'b1; if0.wr_data = 8'(i);
            tick;
            if (if0.empty !== (m_q.size() == 0) || if0.full !== (m_q.size() == DEPTH)) flag_errs++;
        end
        if0.wr_en = 1'b0;
        total++; if (if0.overflow !== 1'b0) begin bad++; $display("FAIL fill1_overflow got=%b want=0", if0.overflow); end
        total++; if (if0.full !== 1'b1) begin bad++; $display("FAIL fill1_full got=%b want=1", if0.full); end
        for (int i = 0; i < 17; i++) begin
            if0.wr_en = 1'b1; if0.wr_data = 8'($urandom);
            tick;
            if (if0.full === 1'b1) saw_full = 1'b1;
            if (if0.overflow !== m_ovf) flag_errs++;
        end
        if0.wr_en = 1'b0;
        total++; if (if0.overflow !== 1'b1 || !saw_full) begin
            bad++; $display("FAIL fill2_overflow got=%b full_seen=%b want=1,1", if0.overflow, saw_full); end
        total++; if (flag_errs != 0) begin bad++; $display("FAIL fill_flags got=%0d want=0", flag_errs); end
        drain_and_compare("fill");
        total++; if (rx_q.size() != 17 || rx_q[0] !== 8'h00 || rx_q[16] !== 8'h10) begin
            bad++; $display("FAIL fill_order got_n=%0d want 00..10", rx_q.size()); end
    endtask

    task automatic test_full_pop;
        int guard;
        do_reset;
        for (int i = 0; i < 17; i++) begin
            if0.wr_en = 1'b1; if0.wr_data = 8'(8'h80 + i);
            tick;
        end
        if0.wr_en = 1'b0;
        guard = 0;
        while (cyc != m_free - 1 && guard < 400) begin tick; guard++; end
        total++; if (guard >= 400) begin bad++; $display("FAIL fullpop_wait got=timeout want=pop edge"); end
        total++; if (if0.full !== 1'b1) begin bad++; $display("FAIL fullpop_pre_full got=%b want=1", if0.full); end
        if0.wr_en = 1'b1; if0.wr_data = 8'hEE;
        tick;
        if0.wr_en = 1'b0;
        total++; if (if0.overflow !== 1'b1 || if0.full !== 1'b0) begin
            bad++; $display("FAIL fullpop_drop got ovf=%b full=%b want ovf=1 full=0", if0.overflow, if0.full); end
        if0.wr_en = 1'b1; if0.wr_data = 8'h3C;
        tick;
        if0.wr_en = 1'b0;
        total++; if (if0.full !== 1'b1) begin bad++; $display("FAIL fullpop_count15 got full=%b want=1", if0.full); end
        drain_and_compare("fullpop");
        total++; if (rx_q.size() != 18 || rx_q[17] !== 8'h3C || rx_q[16] !== 8'h90) begin
            bad++; $display("FAIL fullpop_order got_n=%0d want=18 ending 90,3c", rx_q.size()); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] d;
        int errs;
        do_reset;
        if0.wr_en = 1'b1; if0.wr_data = 8'hA5;
        tick;
        if0.wr_data = 8'h3C;
        tick;
        if0.wr_en = 1'b0;
        repeat (71) tick;
        #2;
        total++; if (if0.tx !== 1'b0) begin bad++; $display("FAIL midrst_pre_tx got=%b want=0", if0.tx); end
        reset = 1'b0;
        #1;
        total++; if (if0.tx !== 1'b1 || if0.busy !== 1'b0 || if0.empty !== 1'b1) begin
            bad++; $display("FAIL midrst_async got tx=%b busy=%b empty=%b want 1,0,1", if0.tx, if0.busy, if0.empty); end
        repeat (2) tick;
        reset = 1'b1;
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (if0.tx !== 1'b1 || if0.busy !== 1'b0 || if0.empty !== 1'b1) errs++;
        end
        total++; if (errs != 0 || rx_q.size() != 0) begin
            bad++; $display("FAIL midrst_idle got bad=%0d rx_n=%0d want 0,0", errs, rx_q.size()); end
        d = 8'($urandom);
        if0.wr_en = 1'b1; if0.wr_data = d;
        tick;
        if0.wr_en = 1'b0;
        repeat (200) tick;
        total++; if (rx_q.size() != 1 || rx_q[0] !== d) begin
            bad++; $display("FAIL midrst_after got_n=%0d want one byte %h", rx_q.size(), d); end
    endtask

    task automatic test_random;
        do_reset;
        for (int i = 0; i < 2500; i++) begin
            if0.wr_en = ($urandom_range(0, 5) == 0);
            if0.wr_data = 8'($urandom);
            tick;
        end
        if0.wr_en = 1'b0;
        drain_and_compare("random");
        total++; if (rx_stop_err != 0) begin bad++; $display("FAIL stop_bits got=%0d want=0", rx_stop_err); end
    endtask

    task automatic test_default_baud;
        logic [7:0] d;
        int errs, busy_cnt;
        d = 8'($urandom);
        tick;
        if1.wr_en = 1'b1; if1.wr_data = d;
        tick;
        if1.wr_en = 1'b0;
        tick;
        total++; if (if1.tx !== 1'b1) begin bad++; $display("FAIL baud_latency got=%b want=1", if1.tx); end
        errs = 0; busy_cnt = 0;
        for (int k = 0; k < 10 * CPB1 + 5; k++) begin
            tick;
            if (if1.tx !== ((k < 10 * CPB1) ? frame_bit(d, k / CPB1) : 1'b1)) errs++;
            if (if1.busy === 1'b1) busy_cnt++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL baud_bits got=%0d bad cycles want=0", errs); end
        total++; if (busy_cnt != 8680) begin bad++; $display("FAIL baud_frame_len got=%0d want=8680", busy_cnt); end
        total++; if (if1.empty !== 1'b1) begin bad++; $display("FAIL baud_empty got=%b want=1", if1.empty); end
    endtask

    initial begin
        if0.wr_en = 1'b0; if0.wr_data = '0;
        if1.wr_en = 1'b0; if1.wr_data = '0;
        test_reset;
        test_single;
        test_back_to_back;
        test_fifo_fill;
        test_full_pop;
        test_reset_mid_frame;
        test_random;
        test_default_baud;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
